// File: rtl/pong_pkg.sv
// Shared types for the ping-pong game: FSM state encoding, winner codes and
// the score defaults also used by the score display and ball datapath.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        RALLY    = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    localparam int DEF_WIN_SCORE = 7;
    localparam int DEF_SCORE_W   = 4;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Match-control bundle between the game sequencer (master) and the
// ball datapath / score display / buttons side (slave).
interface pong_game_ctrl_if
    import pong_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W
);
    logic               start;
    logic               miss_l;
    logic               miss_r;
    logic               tick;
    logic               serve;
    logic               serve_dir;
    logic               ball_en;
    logic [SCORE_W-1:0] sc1;
    logic [SCORE_W-1:0] sc2;
    logic [1:0]         winner;
    logic               reset_game;
    logic [2:0]         state;

    modport master (
        input  start, miss_l, miss_r,
        output tick, serve, serve_dir, ball_en, sc1, sc2, winner, reset_game, state
    );

    modport slave (
        output start, miss_l, miss_r,
        input  tick, serve, serve_dir, ball_en, sc1, sc2, winner, reset_game, state
    );

endinterface

// File: rtl/pong_tick_div.sv
// Frame tick divider: free-running 0..TICK_DIV-1 counter, one-cycle tick
// registered on the cycle after the counter hits its last value.
module pong_tick_div #(
    parameter int TICK_DIV = 100
) (
    input  logic sys_clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (cnt_q == CNT_LAST);
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer: IDLE/SERVE/RALLY/POINT/GAMEOVER FSM, scoring and winner detection.
// Optional build macro WIN_BY_TWO_EN: win needs a two-point lead, with deuce collapse.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV   = 100,
    parameter int WIN_SCORE  = DEF_WIN_SCORE,
    parameter int SCORE_W    = DEF_SCORE_W,
    parameter int HOLD_TICKS = 30
) (
    input  logic             sys_clock,
    input  logic             reset,
    pong_game_ctrl_if.master bus
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(1);
    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] WIN_M1    = SCORE_W'(WIN_SCORE - 1);

    state_t             state_q, state_d;
    logic               start_q;
    logic [SCORE_W-1:0] sc1_q, sc1_d, sc2_q, sc2_d;
    logic [1:0]         winner_q, winner_d;
    logic               dir_q, dir_d;
    logic               serve_q, serve_d;
    logic               rg_q, rg_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               tick;
    logic               start_edge;
    logic [SCORE_W-1:0] sc1_inc, sc2_inc;

    // Scores are sampled only after the POINT hold, so the winner follows the final score.
    function automatic logic [1:0] win_code(input logic [SCORE_W-1:0] a,
                                            input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] a_x, b_x;
        a_x = {1'b0, a};
        b_x = {1'b0, b};
`ifdef WIN_BY_TWO_EN
        if (a >= WIN_S && a_x >= b_x + 2'd2)
            return WINNER_P1;
        if (b >= WIN_S && b_x >= a_x + 2'd2)
            return WINNER_P2;
`else
        if (a_x == {1'b0, WIN_S})
            return WINNER_P1;
        if (b_x == {1'b0, WIN_S})
            return WINNER_P2;
`endif
        return WINNER_NONE;
    endfunction

    pong_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .sys_clock (sys_clock),
        .reset     (reset),
        .tick      (tick)
    );

    assign start_edge = bus.start & ~start_q;
    assign sc1_inc    = sc1_q + 1'b1;
    assign sc2_inc    = sc2_q + 1'b1;

    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            sc1_q    <= '0;
            sc2_q    <= '0;
            winner_q <= WINNER_NONE;
            dir_q    <= 1'b0;
            serve_q  <= 1'b0;
            rg_q     <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.start;
            sc1_q    <= sc1_d;
            sc2_q    <= sc2_d;
            winner_q <= winner_d;
            dir_q    <= dir_d;
            serve_q  <= serve_d;
            rg_q     <= rg_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sc1_d    = sc1_q;
        sc2_d    = sc2_q;
        winner_d = winner_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        serve_d  = 1'b0;
        rg_d     = 1'b0;
        case (state_q)
            IDLE, GAMEOVER: begin
                if (start_edge) begin
                    state_d  = SERVE;
                    sc1_d    = '0;
                    sc2_d    = '0;
                    winner_d = WINNER_NONE;
                    dir_d    = 1'b0;
                    rg_d     = 1'b1;
                end
            end
            SERVE: begin
                if (tick) begin
                    serve_d = 1'b1;
                    state_d = RALLY;
                end
            end
            RALLY: begin
                // A simultaneous double miss is a let: no score, direction kept.
                if (bus.miss_l || bus.miss_r) begin
                    state_d = POINT;
                    hold_d  = HOLD_LOAD;
                    if (bus.miss_r && !bus.miss_l) begin
                        dir_d = 1'b1;
`ifdef WIN_BY_TWO_EN
                        if (sc1_inc == WIN_S && sc2_q == WIN_S) begin
                            sc1_d = WIN_M1;
                            sc2_d = WIN_M1;
                        end else begin
                            sc1_d = sc1_inc;
                        end
`else
                        sc1_d = sc1_inc;
`endif
                    end else if (bus.miss_l && !bus.miss_r) begin
                        dir_d = 1'b0;
`ifdef WIN_BY_TWO_EN
                        if (sc2_inc == WIN_S && sc1_q == WIN_S) begin
                            sc1_d = WIN_M1;
                            sc2_d = WIN_M1;
                        end else begin
                            sc2_d = sc2_inc;
                        end
`else
                        sc2_d = sc2_inc;
`endif
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        if (win_code(sc1_q, sc2_q) != WINNER_NONE) begin
                            state_d  = GAMEOVER;
                            winner_d = win_code(sc1_q, sc2_q);
                        end else begin
                            state_d = SERVE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tick       = tick;
    assign bus.serve      = serve_q;
    assign bus.serve_dir  = dir_q;
    assign bus.ball_en    = (state_q == RALLY);
    assign bus.sc1        = sc1_q;
    assign bus.sc2        = sc2_q;
    assign bus.winner     = winner_q;
    assign bus.reset_game = rg_q;
    assign bus.state      = state_q;

endmodule
